mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_LIMIT, default 8191; highest legal word address.
REQ-002 The block SHALL have parameter STARVE_MAX, default 4; the maximum number of consecutive data grants while fetch waits.
REQ-003 The block SHALL use one clock; reset SHALL be asynchronous and active-low.
REQ-004 The block SHALL have port clk, input, 1 bit; the system clock, rising edge active.
REQ-005 The block SHALL have port rst_n, input, 1 bit; asynchronous active-low reset.
REQ-006 The block SHALL have port if_req, input, 1 bit; fetch read request, level, held until if_ready.
REQ-007 The block SHALL have port if_addr, input, 64 bits; fetch word address.
REQ-008 The block SHALL have ports if_ready (output, 1 bit), if_rdata (output, 64 bits) and if_err (output, 1 bit); fetch completion strobe, read data and address error.
REQ-009 The block SHALL have port dm_req, input, 1 bit; data request, level, held until dm_ready.
REQ-010 The block SHALL have ports dm_we (input, 1 bit), dm_addr (input, 64 bits) and dm_wdata (input, 64 bits); write enable, address and write data.
REQ-011 The block SHALL have ports dm_ready (output, 1 bit), dm_rdata (output, 64 bits) and dm_err (output, 1 bit).
REQ-012 The block SHALL have ports mem_en, mem_we (output, 1 bit each), mem_addr (output, 13 bits) and mem_wdata (output, 64 bits); the single-port RAM strobe, address and data.
REQ-013 The block SHALL have port mem_rdata, input, 64 bits; RAM read data, valid one cycle after mem_en with mem_we=0.
REQ-014 The block SHALL have port stat, output, 3 bits; 1=AOK, 2=ADR on any address error, sticky until reset.

Function
REQ-015 The FSM SHALL have states IDLE, ACCESS and RESP; IDLE->ACCESS on an edge with any request; ACCESS->RESP unconditionally; RESP->IDLE unconditionally.
REQ-016 In IDLE, the arbiter SHALL select the data requester when only dm_req is asserted, or when both are asserted and starve_cnt < STARVE_MAX.
REQ-017 Otherwise, the arbiter SHALL select fetch.
REQ-018 The winner's address, we and wdata SHALL be latched on the IDLE->ACCESS edge; later input changes SHALL be ignored until the return to IDLE.
REQ-019 starve_cnt SHALL increment, saturating at STARVE_MAX, on a data grant while if_req=1; it SHALL clear on a fetch grant and on a data grant while if_req=0.
REQ-020 In ACCESS with the latched address <= ADDR_LIMIT, the block SHALL assert mem_en=1, mem_addr=addr[12:0], mem_we=latched we (always 0 for fetch), and mem_wdata=latched wdata.
REQ-021 In ACCESS with the latched address > ADDR_LIMIT (full 64-bit compare), mem_en SHALL stay 0 and the block SHALL latch err=1.
REQ-022 On the ACCESS->RESP edge, the block SHALL register mem_rdata into the winner's rdata; for writes or errors, rdata SHALL be 0.
REQ-023 In RESP, exactly the winner's ready SHALL be 1 for one cycle, with its err valid; the other requester's ready and err SHALL be 0.
REQ-024 Latency SHALL be two cycles from the request-sampling edge to the ready cycle; the ready cycle SHALL be followed by one mandatory IDLE cycle.
REQ-025 If the winner drops its req before ready, the transaction SHALL still complete, including the write, and ready SHALL still pulse.
REQ-026 mem_en SHALL never be 1 outside ACCESS; at most one ready SHALL be high in any cycle.
REQ-027 stat SHALL be set to 2 on the RESP cycle of any errored transaction and SHALL hold until reset.

Reset
REQ-028 While rst_n=0, the block SHALL asynchronously force state=IDLE, starve_cnt=0, stat=1, and all ready, err, mem_en, mem_we, addr, data and rdata outputs to 0.
REQ-029 Reset asserted mid-transaction SHALL abort the transaction with no ready pulse; a write SHALL occur only if ACCESS completed before reset.
REQ-030 After rst_n rises, the first request SHALL be sampled on the first rising clk edge.

Verification
REQ-031 The bench SHALL apply dm_req=1, dm_we=1, dm_addr=0x10, dm_wdata=0xDEAD -> mem_en=mem_we=1, mem_addr=0x10 in ACCESS, dm_ready pulse two cycles after sampling, dm_err=0.
REQ-032 The bench SHALL then apply dm_req=1, dm_we=0, dm_addr=0x10 -> dm_rdata=0xDEAD with dm_ready, stat=1.
REQ-033 The bench SHALL hold if_req and dm_req constantly high -> four data grants, then one fetch grant, repeating; starve_cnt clears after each fetch grant.
REQ-034 The bench SHALL apply if_req=1, if_addr=8192 -> mem_en stays 0, if_ready=1, if_err=1, if_rdata=0, stat=2 and remains 2 after later good accesses.
REQ-035 The bench SHALL drop rst_n during the ACCESS of a dm write to 0x20 -> all outputs go 0 immediately, no dm_ready, and the read of 0x20 after reset reflects whether ACCESS completed.
REQ-036 The bench SHALL apply dm_req for one cycle only, dm_addr=5 -> the transaction still completes and dm_ready pulses once.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// ============================================================================
// mem_port_arbiter : two-requester (fetch / data) arbiter onto one RAM port
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_port_arbiter #(
  parameter int ADDR_LIMIT = 8191,
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [63:0] if_addr,
  output logic        if_ready,
  output logic [63:0] if_rdata,
  output logic        if_err,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [63:0] dm_addr,
  input  logic [63:0] dm_wdata,
  output logic        dm_ready,
  output logic [63:0] dm_rdata,
  output logic        dm_err,
  output logic        mem_en,
  output logic        mem_we,
  output logic [12:0] mem_addr,
  output logic [63:0] mem_wdata,
  input  logic [63:0] mem_rdata,
  output logic [2:0]  stat
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;

  localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] c_starve_max = SW'(STARVE_MAX);
  localparam logic [63:0]   c_limit      = 64'(ADDR_LIMIT);
  localparam logic [2:0]    c_stat_aok   = 3'd1;
  localparam logic [2:0]    c_stat_adr   = 3'd2;

  logic [1:0]    r_state;
  logic          r_sel_dm;
  logic [63:0]   r_addr;
  logic          r_we;
  logic [63:0]   r_wdata;
  logic [SW-1:0] r_starve;
  logic          r_err;
  logic [63:0]   r_rdata;
  logic [2:0]    r_stat;

  logic w_pick_dm;
  logic w_bad;
  logic w_access;
  logic w_resp;

  // Data wins unless fetch has already waited through STARVE_MAX data grants.
  assign w_pick_dm = dm_req && (!if_req || (r_starve < c_starve_max));
  assign w_bad     = (r_addr > c_limit);
  assign w_access  = (r_state == S_ACCESS);
  assign w_resp    = (r_state == S_RESP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_sel_dm <= 1'b0;
      r_addr   <= 64'd0;
      r_we     <= 1'b0;
      r_wdata  <= 64'd0;
      r_starve <= '0;
      r_err    <= 1'b0;
      r_rdata  <= 64'd0;
      r_stat   <= c_stat_aok;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (if_req || dm_req) begin
            r_state  <= S_ACCESS;
            r_sel_dm <= w_pick_dm;
            r_addr   <= w_pick_dm ? dm_addr : if_addr;
            r_we     <= w_pick_dm & dm_we;
            r_wdata  <= w_pick_dm ? dm_wdata : 64'd0;
            if (w_pick_dm && if_req) begin
              if (r_starve != c_starve_max) r_starve <= r_starve + 1'b1;
            end else begin
              r_starve <= '0;
            end
          end
        end
        S_ACCESS: begin
          r_state <= S_RESP;
          r_err   <= w_bad;
          r_rdata <= (w_bad || r_we) ? 64'd0 : mem_rdata;
          if (w_bad) r_stat <= c_stat_adr;
        end
        S_RESP: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // All RAM strobes are derived from state so reset clears them immediately.
  assign mem_en    = w_access && !w_bad;
  assign mem_we    = mem_en && r_we;
  assign mem_addr  = mem_en ? r_addr[12:0] : 13'd0;
  assign mem_wdata = mem_en ? r_wdata : 64'd0;

  assign dm_ready  = w_resp && r_sel_dm;
  assign if_ready  = w_resp && !r_sel_dm;
  assign dm_err    = dm_ready && r_err;
  assign if_err    = if_ready && r_err;
  assign dm_rdata  = dm_ready ? r_rdata : 64'd0;
  assign if_rdata  = if_ready ? r_rdata : 64'd0;
  assign stat      = r_stat;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
// tb_mem_port_arbiter : directed vector bench with a behavioural RAM
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req;
  logic [63:0] if_addr;
  logic        if_ready;
  logic [63:0] if_rdata;
  logic        if_err;
  logic        dm_req;
  logic        dm_we;
  logic [63:0] dm_addr;
  logic [63:0] dm_wdata;
  logic        dm_ready;
  logic [63:0] dm_rdata;
  logic        dm_err;
  logic        mem_en;
  logic        mem_we;
  logic [12:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [63:0] mem_rdata;
  logic [2:0]  stat;

  int n_chk  = 0;
  int n_fail = 0;

  mem_port_arbiter #(.ADDR_LIMIT(8191), .STARVE_MAX(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready),
    .if_rdata(if_rdata), .if_err(if_err),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_ready(dm_ready), .dm_rdata(dm_rdata), .dm_err(dm_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .stat(stat)
  );

  always #5 clk = ~clk;

  // Read data is presented combinationally so it is stable by the end of ACCESS.
  logic [63:0] ram [0:8191] = '{default: 64'd0};
  always @(posedge clk) begin
    if (mem_en && mem_we) ram[mem_addr] <= mem_wdata;
  end
  assign mem_rdata = ram[mem_addr];

  typedef struct {
    logic        use_if;
    logic        we;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [63:0] exp_rdata;
    logic        exp_err;
    logic [2:0]  exp_stat;
  } vec_t;

  vec_t tbl [12];

  function automatic vec_t mk(input logic use_if, input logic we,
                              input logic [63:0] addr, input logic [63:0] wdata,
                              input logic [63:0] exp_rdata, input logic exp_err,
                              input logic [2:0] exp_stat);
    vec_t v;
    v.use_if = use_if; v.we = we; v.addr = addr; v.wdata = wdata;
    v.exp_rdata = exp_rdata; v.exp_err = exp_err; v.exp_stat = exp_stat;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Entered and left at #1 after an edge with the DUT in IDLE.
  task automatic do_txn(input string nm, input vec_t v);
    logic [12:0] a13;
    a13 = v.addr[12:0];
    if (v.use_if) begin
      if_req = 1'b1; if_addr = v.addr;
    end else begin
      dm_req = 1'b1; dm_we = v.we; dm_addr = v.addr; dm_wdata = v.wdata;
    end
    @(posedge clk); #1;
    chk({nm, "_mem_en"}, mem_en, !v.exp_err);
    if (!v.exp_err) begin
      chk({nm, "_mem_we"}, mem_we, v.we && !v.use_if);
      chk({nm, "_mem_addr"}, mem_addr, a13);
      if (v.we) chk({nm, "_mem_wdata"}, mem_wdata, v.wdata);
    end
    chk({nm, "_early_rdy"}, if_ready | dm_ready, 0);
    @(posedge clk); #1;
    chk({nm, "_rdy"}, v.use_if ? if_ready : dm_ready, 1);
    chk({nm, "_other_rdy"}, v.use_if ? dm_ready : if_ready, 0);
    chk({nm, "_err"}, v.use_if ? if_err : dm_err, v.exp_err);
    chk({nm, "_rdata"}, v.use_if ? if_rdata : dm_rdata, v.exp_rdata);
    chk({nm, "_stat"}, stat, v.exp_stat);
    chk({nm, "_en_resp"}, mem_en, 0);
    if_req = 1'b0; dm_req = 1'b0;
    @(posedge clk); #1;
    chk({nm, "_idle"}, {if_ready, dm_ready, mem_en}, 0);
  endtask

  initial begin
    int     cnt;
    logic   got;
    logic   exp_dm;
    int     pulses;

    rst_n = 1'b0; if_req = 1'b0; if_addr = 64'd0;
    dm_req = 1'b0; dm_we = 1'b0; dm_addr = 64'd0; dm_wdata = 64'd0;

    tbl[0]  = mk(0, 1, 64'h10,        64'hDEAD,                 64'd0,                    0, 3'd1);
    tbl[1]  = mk(0, 0, 64'h10,        64'd0,                    64'hDEAD,                 0, 3'd1);
    tbl[2]  = mk(1, 0, 64'h10,        64'd0,                    64'hDEAD,                 0, 3'd1);
    tbl[3]  = mk(0, 1, 64'd8191,      64'h1234_5678_9ABC_DEF0,  64'd0,                    0, 3'd1);
    tbl[4]  = mk(1, 0, 64'd8191,      64'd0,                    64'h1234_5678_9ABC_DEF0,  0, 3'd1);
    tbl[5]  = mk(0, 0, 64'h11,        64'd0,                    64'd0,                    0, 3'd1);
    tbl[6]  = mk(1, 0, 64'd8192,      64'd0,                    64'd0,                    1, 3'd2);
    tbl[7]  = mk(0, 1, 64'h30,        64'h55,                   64'd0,                    0, 3'd2);
    tbl[8]  = mk(0, 0, 64'h30,        64'd0,                    64'h55,                   0, 3'd2);
    tbl[9]  = mk(0, 1, 64'h1_0000_0010, 64'hBAD,                64'd0,                    1, 3'd2);
    tbl[10] = mk(0, 0, 64'h10,        64'd0,                    64'hDEAD,                 0, 3'd2);
    tbl[11] = mk(1, 0, 64'h8000_0000_0000_0000, 64'd0,          64'd0,                    1, 3'd2);

    #12;
    chk("rst_stat", stat, 3'd1);
    chk("rst_outs", {if_ready, dm_ready, if_err, dm_err, mem_en, mem_we}, 0);
    chk("rst_data", {mem_addr, mem_wdata, if_rdata, dm_rdata}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      do_txn($sformatf("v%0d", i), tbl[i]);
    end

    // Both requesters held high: four data grants then one fetch grant.
    if_req = 1'b1; if_addr = 64'h10;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 64'h30;
    for (int g = 0; g < 15; g++) begin
      cnt = 0; got = 1'b0;
      exp_dm = (g % 5) != 4;
      while (!got && cnt < 8) begin
        @(posedge clk); #1;
        cnt++;
        chk("one_ready", if_ready & dm_ready, 0);
        if (if_ready || dm_ready) got = 1'b1;
      end
      chk($sformatf("starve_g%0d_timeout", g), got, 1);
      chk($sformatf("starve_g%0d_dm", g), dm_ready, exp_dm);
      chk($sformatf("starve_g%0d_rdata", g), exp_dm ? dm_rdata : if_rdata,
          exp_dm ? 64'h55 : 64'hDEAD);
    end
    if_req = 1'b0; dm_req = 1'b0;
    @(posedge clk); #1;

    // One-cycle request; later input changes must not affect the transaction.
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 64'd5; dm_wdata = 64'h77;
    @(posedge clk); #1;
    dm_req = 1'b0; dm_addr = 64'd9; dm_wdata = 64'h99;
    chk("short_mem_en", mem_en, 1);
    chk("short_mem_addr", mem_addr, 13'd5);
    chk("short_mem_wdata", mem_wdata, 64'h77);
    pulses = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (dm_ready) pulses++;
    end
    chk("short_pulses", pulses, 1);
    do_txn("short_rd", mk(0, 0, 64'd5, 64'd0, 64'h77, 0, 3'd2));
    do_txn("short_rd9", mk(0, 0, 64'd9, 64'd0, 64'd0, 0, 3'd2));

    // Reset dropped during ACCESS of a write to 0x20.
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 64'h20; dm_wdata = 64'hBEEF;
    @(posedge clk); #1;
    chk("rmid_access", mem_en, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rmid_en", {mem_en, mem_we}, 0);
    chk("rmid_addr", {mem_addr, mem_wdata}, 0);
    chk("rmid_stat", stat, 3'd1);
    dm_req = 1'b0;
    pulses = 0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      if (dm_ready || if_ready) pulses++;
    end
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      if (dm_ready || if_ready) pulses++;
    end
    chk("rmid_no_ready", pulses, 0);
    do_txn("rmid_rd20", mk(0, 0, 64'h20, 64'd0, 64'd0, 0, 3'd1));
    do_txn("rmid_rd10", mk(1, 0, 64'h10, 64'd0, 64'hDEAD, 0, 3'd1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
